// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide controller.
// Optional build macro: DIVZERO_FAST_EN (early completion of divide-by-zero).
package multdiv_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned DEF_MULT_ITERS = 16;
  localparam int unsigned DEF_DIV_ITERS  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter with synchronous clear, enable and terminal-count compare.
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter int unsigned ITERS = DEF_MULT_ITERS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  output logic [WORD_W-1:0] count,
  output logic              tc_c
);

  assign tc_c = (count == WORD_W'(ITERS));

  // Clear has priority so a restart always begins at the load cycle.
  always_ff @(posedge clk) begin
    if (!reset_n)   count <= '0;
    else if (clr)   count <= '0;
    else if (en)    count <= count + WORD_W'(1);
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing control for an iterative multiplier and restoring divider.
// Optional build macro: DIVZERO_FAST_EN (divide-by-zero completes one edge after start).
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned MULT_ITERS = DEF_MULT_ITERS,
  parameter int unsigned DIV_ITERS  = DEF_DIV_ITERS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  input  logic [WORD_W-1:0] data_operandA,
  input  logic [WORD_W-1:0] data_operandB,
  input  logic [WORD_W-1:0] mult_product,
  input  logic              mult_ovf,
  input  logic [WORD_W-1:0] div_quotient,
  output logic [WORD_W-1:0] op_a,
  output logic [WORD_W-1:0] op_b,
  output logic [WORD_W-1:0] mult_counter,
  output logic [WORD_W-1:0] div_counter,
  output logic [WORD_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY,
  output logic              busy
);

  md_state_e         state, state_n;
  logic              mult_clr, mult_en, mult_tc;
  logic              div_clr, div_en, div_tc;
  logic              div_fin, ld_ops, ld_res;
  logic [WORD_W-1:0] res_n;
  logic              exc_n;

  multdiv_counter #(.ITERS(MULT_ITERS)) u_mult_cnt (
    .clk(clk), .reset_n(reset_n), .clr(mult_clr), .en(mult_en),
    .count(mult_counter), .tc_c(mult_tc)
  );

  multdiv_counter #(.ITERS(DIV_ITERS)) u_div_cnt (
    .clk(clk), .reset_n(reset_n), .clr(div_clr), .en(div_en),
    .count(div_counter), .tc_c(div_tc)
  );

  // State register plus registered outputs, all loaded from next-state decode.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      op_a           <= '0;
      op_b           <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      data_resultRDY <= (state_n == DONE);
      busy           <= (state_n == MULT) || (state_n == DIV);
      if (ld_ops) begin
        op_a <= data_operandA;
        op_b <= data_operandB;
      end
      if (ld_res) begin
        data_result    <= res_n;
        data_exception <= exc_n;
      end
    end
  end

  // Next-state and control decode; a start pulse overrides whatever the state wanted.
  always_comb begin
    state_n  = state;
    mult_clr = 1'b0;
    mult_en  = 1'b0;
    div_clr  = 1'b0;
    div_en   = 1'b0;
    div_fin  = 1'b0;
    ld_ops   = 1'b0;
    ld_res   = 1'b0;
    res_n    = '0;
    exc_n    = 1'b0;

    case (state)
      MULT: begin
        mult_en = 1'b1;
        if (mult_tc) begin
          ld_res  = 1'b1;
          res_n   = mult_product;
          exc_n   = mult_ovf;
          state_n = DONE;
        end
      end
      DIV: begin
        div_en  = 1'b1;
        div_fin = div_tc;
`ifdef DIVZERO_FAST_EN
        if (op_b == '0) begin
          div_en  = 1'b0;
          div_fin = 1'b1;
        end
`endif
        if (div_fin) begin
          ld_res  = 1'b1;
          res_n   = (op_b == '0) ? '0 : div_quotient;
          exc_n   = (op_b == '0);
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (ctrl_MULT) begin
      state_n  = MULT;
      ld_ops   = 1'b1;
      ld_res   = 1'b0;
      mult_clr = 1'b1;
      div_clr  = 1'b1;
    end else if (ctrl_DIV) begin
      state_n  = DIV;
      ld_ops   = 1'b1;
      ld_res   = 1'b0;
      mult_clr = 1'b1;
      div_clr  = 1'b1;
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl; the bench plays the datapaths.
`timescale 1ns/1ps
module tb_multdiv_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic [31:0] mult_product = '0, div_quotient = '0;
  logic        mult_ovf = 1'b0;
  logic [31:0] op_a, op_b, mult_counter, div_counter, data_result;
  logic        data_exception, data_resultRDY, busy;

  int n_asserts = 0;
  int n_fail    = 0;

`ifdef DIVZERO_FAST_EN
  localparam int DIVZ_LAT = 1;
`else
  localparam int DIVZ_LAT = 33;
`endif

  multdiv_ctrl dut (
    .clk(clk), .reset_n(reset_n), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .mult_product(mult_product), .mult_ovf(mult_ovf), .div_quotient(div_quotient),
    .op_a(op_a), .op_b(op_b), .mult_counter(mult_counter), .div_counter(div_counter),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    tick();
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
  endtask

  // Counts edges after the start edge until RDY appears; bounded.
  task automatic wait_rdy(input string tag, input int exp_lat);
    int k = 0;
    while (!data_resultRDY && k < 100) begin
      tick();
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_op_a"}, op_a, 32'd0);
    chk({tag, "_op_b"}, op_b, 32'd0);
    chk({tag, "_mcnt"}, mult_counter, 32'd0);
    chk({tag, "_dcnt"}, div_counter, 32'd0);
    chk({tag, "_result"}, data_result, 32'd0);
    chk({tag, "_exc"}, 32'(data_exception), 32'd0);
    chk({tag, "_rdy"}, 32'(data_resultRDY), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int rdy_seen;

    // Reset
    tick(); tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Multiply 7 * -3
    mult_product = 32'hFFFF_FFEB; mult_ovf = 1'b0;
    start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    chk("mul_busy", 32'(busy), 32'd1);
    chk("mul_op_a", op_a, 32'd7);
    chk("mul_op_b", op_b, 32'hFFFF_FFFD);
    chk("mul_cnt0", mult_counter, 32'd0);
    wait_rdy("mul", 17);
    chk("mul_result", data_result, 32'hFFFF_FFEB);
    chk("mul_exc", 32'(data_exception), 32'd0);
    chk("mul_busy_done", 32'(busy), 32'd0);
    mult_product = 32'h1234_5678;
    tick();
    chk("mul_rdy_1cyc", 32'(data_resultRDY), 32'd0);
    chk("mul_hold", data_result, 32'hFFFF_FFEB);

    // Divide 100 / 7
    div_quotient = 32'd14;
    start(1'b0, 1'b1, 32'd100, 32'd7);
    chk("div_busy", 32'(busy), 32'd1);
    chk("div_mcnt", mult_counter, 32'd0);
    wait_rdy("div", 33);
    chk("div_result", data_result, 32'd14);
    chk("div_exc", 32'(data_exception), 32'd0);
    tick();

    // Divide by zero
    div_quotient = 32'hDEAD_BEEF;
    start(1'b0, 1'b1, 32'd55, 32'd0);
    wait_rdy("divz", DIVZ_LAT);
    chk("divz_result", data_result, 32'd0);
    chk("divz_exc", 32'(data_exception), 32'd1);
    tick();

    // Multiply overflow
    mult_product = 32'd0; mult_ovf = 1'b1;
    start(1'b1, 1'b0, 32'h4000_0000, 32'd4);
    wait_rdy("ovf", 17);
    chk("ovf_exc", 32'(data_exception), 32'd1);
    chk("ovf_result", data_result, 32'd0);
    tick();
    mult_ovf = 1'b0;

    // Abort multiply with divide at cycle 5
    mult_product = 32'd123; div_quotient = 32'd3;
    start(1'b1, 1'b0, 32'd11, 32'd12);
    tick(); tick(); tick(); tick();
    chk("abort_mcnt", mult_counter, 32'd4);
    chk("abort_dcnt", div_counter, 32'd0);
    start(1'b0, 1'b1, 32'd9, 32'd3);
    chk("abort_op_a", op_a, 32'd9);
    chk("abort_mcnt_clr", mult_counter, 32'd0);
    wait_rdy("abort", 33);
    chk("abort_result", data_result, 32'd3);
    tick();

    // Reset mid-multiply
    mult_product = 32'd77;
    start(1'b1, 1'b0, 32'd5, 32'd6);
    for (int i = 0; i < 7; i++) tick();
    reset_n = 1'b0;
    tick();
    chk_all_zero("midrst");
    reset_n = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (data_resultRDY) rdy_seen++;
    end
    chk("midrst_no_rdy", 32'(rdy_seen), 32'd0);

    // Reset overrides a simultaneous start
    reset_n = 1'b0;
    start(1'b1, 1'b0, 32'd1, 32'd2);
    chk("rststart_busy", 32'(busy), 32'd0);
    chk("rststart_op_a", op_a, 32'd0);
    reset_n = 1'b1;
    tick();

    // Both starts together: multiply wins; then a start sampled in DONE
    mult_product = 32'd55; div_quotient = 32'd66;
    start(1'b1, 1'b1, 32'd5, 32'd11);
    chk("both_dcnt", div_counter, 32'd0);
    wait_rdy("both", 17);
    chk("both_result", data_result, 32'd55);
    start(1'b0, 1'b1, 32'd9, 32'd3);
    chk("done_start_rdy", 32'(data_resultRDY), 32'd0);
    chk("done_start_busy", 32'(busy), 32'd1);
    chk("done_start_hold", data_result, 32'd55);
    wait_rdy("done_start", 33);
    chk("done_start_result", data_result, 32'd66);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter MULT_ITERS, default 16, meaning the number of radix-4 Booth iterations after the load cycle.
REQ-002 SHALL have parameter DIV_ITERS, default 32, meaning the number of restoring-divide iterations after the load cycle.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port ctrl_MULT, input, 1, one-cycle start pulse for multiply.
REQ-006 SHALL have port ctrl_DIV, input, 1, one-cycle start pulse for divide.
REQ-007 SHALL have ports data_operandA and data_operandB, input, 32 each, operands sampled on the start edge.
REQ-008 SHALL have ports mult_product, input, 32, and mult_ovf, input, 1, from the multiplier datapath.
REQ-009 SHALL have port div_quotient, input, 32, from the divider datapath.
REQ-010 SHALL have ports op_a and op_b, output, 32 each, latched operands driven to both datapaths.
REQ-011 SHALL have ports mult_counter and div_counter, output, 32 each, iteration counters; 0 means the load cycle.
REQ-012 SHALL have ports data_result, output, 32; data_exception, output, 1; data_resultRDY, output, 1; busy, output, 1.

Function
REQ-013 SHALL implement FSM states IDLE, MULT, DIV and DONE.
REQ-014 SHALL, on an edge with ctrl_MULT=1 in any state, latch op_a/op_b, clear mult_counter to 0, and enter MULT.
REQ-015 SHALL, on an edge with ctrl_DIV=1 and ctrl_MULT=0 in any state, latch op_a/op_b, clear div_counter to 0, and enter DIV.
REQ-016 SHALL give ctrl_MULT priority when both start pulses are high on the same edge.
REQ-017 SHALL treat a start while in MULT or DIV as an abort-and-restart: the old result is discarded and data_resultRDY is never raised for it.
REQ-018 SHALL increment the active counter by 1 per edge in MULT or DIV and hold the inactive counter at 0.
REQ-019 SHALL, in MULT, on the edge where mult_counter == MULT_ITERS, register data_result <= mult_product and data_exception <= mult_ovf, then enter DONE.
REQ-020 SHALL, in DIV, on the edge where div_counter == DIV_ITERS, register data_result <= div_quotient and data_exception <= 0, then enter DONE.
REQ-021 SHALL, in DIV with op_b == 0 at completion, force data_result to 0 and data_exception to 1.
REQ-022 SHALL assert data_resultRDY for exactly the one cycle spent in DONE, then return to IDLE.
REQ-023 SHALL give a multiply latency of start edge plus MULT_ITERS+1 edges to the RDY cycle (17 with defaults), and a divide latency of DIV_ITERS+1 edges (33).
REQ-024 SHALL, on a start sampled in DONE, still show RDY=1 and the old result during that DONE cycle, then proceed as REQ-014/REQ-015.
REQ-025 SHALL hold data_result and data_exception stable from DONE until the next completion.
REQ-026 SHALL drive busy high exactly when the state is MULT or DIV.

Reset
REQ-027 SHALL, on an edge with reset_n=0, force IDLE, both counters 0, op_a/op_b 0, data_result 0, and data_exception, data_resultRDY and busy 0.
REQ-028 SHALL let reset mid-operation abort the operation with no RDY pulse, and SHALL let reset override a start sampled on the same edge.

Configuration
REQ-029 SHALL, with DIVZERO_FAST_EN defined, on a ctrl_DIV start with data_operandB == 0, go directly to DONE on the next edge with result 0 and exception 1 (latency 1); div_counter stays 0.
REQ-030 SHALL, without DIVZERO_FAST_EN, run divide-by-zero for the full DIV_ITERS+1 edges and flag it per REQ-021.

Structure
REQ-031 SHALL place the FSM state enum, default iteration constants and the 32-bit word width in shared package multdiv_pkg.
REQ-032 SHALL implement the iteration counter, with clear, enable and terminal-count compare, as the single sub-module multdiv_counter, instantiated once per datapath.

Verification
REQ-033 SHALL cover: ctrl_MULT with A=7, B=-3 -> RDY high exactly 17 cycles later, result -21, exception 0.
REQ-034 SHALL cover: ctrl_DIV with A=100, B=7 -> RDY after 33 cycles, result 14, exception 0.
REQ-035 SHALL cover: ctrl_DIV with B=0 -> result 0, exception 1, RDY at cycle 33 without the macro and at cycle 1 with it.
REQ-036 SHALL cover: ctrl_MULT with A=0x40000000, B=4 and mult_ovf=1 -> exception 1 in the RDY cycle.
REQ-037 SHALL cover: ctrl_MULT, then ctrl_DIV (A=9, B=3) at cycle 5 -> no multiply RDY; one RDY 33 cycles after the DIV start, result 3.
REQ-038 SHALL cover: reset_n low at cycle 8 of a multiply -> all outputs 0 next edge, no RDY; both starts high together -> multiply performed.
